// File: rtl/nib_ser.sv
// nib_ser -- sending end of the 4-bit CE-strobed nibble bus.
//
// Accepts a 4*NNIB-bit word over an LD/RDY handshake. It then emits the word
// as NNIB nibbles, least-significant first. Each nibble is qualified by a
// one-cycle CE strobe, and GAP idle cycles separate consecutive strobes of
// one word. All outputs come straight from flops.
//
// Parameters:
//   NNIB  nibbles per word (2..16)
//   GAP   idle cycles between strobes of one word (0..15)
//
// Ports:
//   CK    in   clock, all state changes on the rising edge
//   RST   in   synchronous active-high reset (aborts any word in flight)
//   W     in   parallel word, sampled only on the accepting edge
//   LD    in   load request, accepted on an edge where LD=1 and RDY=1
//   RDY   out  block can accept a word
//   D     out  current nibble (held between strobes and after a word)
//   CE    out  one-cycle strobe qualifying D
//   LAST  out  high with CE on the final nibble of a word
//   BUSY  out  word in flight, always ~RDY
module nib_ser #(
  parameter int NNIB = 4,
  parameter int GAP  = 0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [4*NNIB-1:0] W,
  input  logic              LD,
  output logic              RDY,
  output logic [3:0]        D,
  output logic              CE,
  output logic              LAST,
  output logic              BUSY
);

  localparam int WW  = 4 * NNIB;
  localparam int NCW = $clog2(NNIB);

  localparam logic [NCW-1:0] NC_LAST   = NCW'(NNIB - 1);
  localparam logic [NCW-1:0] NC_PENULT = NCW'(NNIB - 2);
  // GC counts the remaining idle cycles down to zero. With GAP==0 the WAIT
  // state is never entered, so the load value is irrelevant.
  localparam logic [3:0]     GC_LOAD   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t         state_reg;
  // The shift register holds the nibbles not yet placed on D. The nibble
  // being strobed already sits in d_reg, so D is a true flop output.
  logic [WW-1:0]  sr_reg;
  logic [NCW-1:0] nc_reg;
  logic [3:0]     gc_reg;
  logic           rdy_reg;
  logic [3:0]     d_reg;
  logic           ce_reg;
  logic           last_reg;

  always_ff @(posedge CK) begin
    if (RST) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      nc_reg    <= '0;
      gc_reg    <= '0;
      rdy_reg   <= 1'b1;
      d_reg     <= 4'h0;
      ce_reg    <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ce_reg   <= 1'b0;
          last_reg <= 1'b0;
          if (LD) begin
            // Nibble 0 goes straight to D; the rest waits in the shifter.
            sr_reg    <= {4'h0, W[WW-1:4]};
            d_reg     <= W[3:0];
            nc_reg    <= '0;
            ce_reg    <= 1'b1;
            last_reg  <= 1'b0;  // NNIB >= 2, so nibble 0 is never last
            rdy_reg   <= 1'b0;
            state_reg <= SEND;
          end
        end

        SEND: begin
          if (last_reg) begin
            ce_reg    <= 1'b0;
            last_reg  <= 1'b0;
            rdy_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            nc_reg <= nc_reg + 1'b1;
            if (GAP == 0) begin
              // Back-to-back strobes: stay in SEND and present the next nibble.
              d_reg    <= sr_reg[3:0];
              sr_reg   <= {4'h0, sr_reg[WW-1:4]};
              last_reg <= (nc_reg == NC_PENULT);
            end else begin
              gc_reg    <= GC_LOAD;
              ce_reg    <= 1'b0;
              state_reg <= WAIT;
            end
          end
        end

        WAIT: begin
          if (gc_reg == 4'd0) begin
            // nc_reg was already advanced on leaving SEND.
            d_reg     <= sr_reg[3:0];
            sr_reg    <= {4'h0, sr_reg[WW-1:4]};
            ce_reg    <= 1'b1;
            last_reg  <= (nc_reg == NC_LAST);
            state_reg <= SEND;
          end else begin
            gc_reg <= gc_reg - 4'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign RDY  = rdy_reg;
  assign BUSY = ~rdy_reg;
  assign D    = d_reg;
  assign CE   = ce_reg;
  assign LAST = last_reg;

endmodule

// File: tb/tb_nib_ser.sv
// Testbench for nib_ser. It runs two instances from the same stimulus: one
// with GAP=0 and one with GAP=2, both with NNIB=4. When a word is accepted,
// the stimulus side pushes the expected strobes into a scoreboard queue. The
// timing of each strobe is computed from the word-level timing rules. A
// separate monitor on the falling edge pops and checks every strobe. It also
// checks RDY/BUSY, LAST and the held value of D on every cycle.
module tb_nib_ser;

  localparam int NN = 4;
  localparam int NI = 2;
  localparam int WW = 4 * NN;

  logic          CK  = 1'b0;
  logic          RST = 1'b1;
  logic          LD  = 1'b0;
  logic [WW-1:0] W   = '0;

  logic [NI-1:0]      rdy;
  logic [NI-1:0]      ce;
  logic [NI-1:0]      last;
  logic [NI-1:0]      busy;
  logic [NI-1:0][3:0] d;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      nib_ser #(.NNIB(NN), .GAP(gi * 2)) u_dut (
        .CK  (CK),
        .RST (RST),
        .W   (W),
        .LD  (LD),
        .RDY (rdy[gi]),
        .D   (d[gi]),
        .CE  (ce[gi]),
        .LAST(last[gi]),
        .BUSY(busy[gi])
      );
    end
  endgenerate

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // Sink registers: 4-bit clock-enabled registers fed by D/CE.
  logic [NI-1:0][3:0] sink = '0;
  always @(posedge CK) begin
    for (int i = 0; i < NI; i++)
      if (ce[i]) sink[i] <= d[i];
  end

  // ---------------- reference model (stimulus side) ----------------
  typedef struct {
    int         inst;
    int         cyc;
    logic [3:0] nib;
    logic       lst;
  } ev_t;

  ev_t exp_q[$];
  int  busy_from[NI];
  int  ready_at[NI];
  int  acc_cnt[NI];

  function automatic int gap_of(input int i);
    return i * 2;
  endfunction

  // These inputs are applied in cycle c = cyc and sampled at the edge that ends it.
  task automatic drive(input logic ld, input logic [WW-1:0] w, input logic rst);
    int c;
    int g;
    LD  = ld;
    W   = w;
    RST = rst;
    c   = cyc;
    for (int i = 0; i < NI; i++) begin
      g = gap_of(i);
      if (rst) begin
        // An abort at edge c cancels every strobe after cycle c.
        for (int j = exp_q.size() - 1; j >= 0; j--)
          if (exp_q[j].inst == i && exp_q[j].cyc > c) exp_q.delete(j);
        if (ready_at[i] > c + 1) ready_at[i] = c + 1;
      end else if (ld && !(busy_from[i] <= c && c < ready_at[i])) begin
        for (int j = 0; j < NN; j++) begin
          ev_t e;
          e.inst = i;
          e.cyc  = c + 1 + j * (g + 1);
          e.nib  = w[4*j +: 4];
          e.lst  = (j == NN - 1);
          exp_q.push_back(e);
        end
        busy_from[i] = c + 1;
        ready_at[i]  = c + 2 + (NN - 1) * (g + 1);
        acc_cnt[i]++;
      end
    end
    @(posedge CK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, W, 1'b0);
  endtask

  // ---------------- monitor / checker ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic          mon_en   = 1'b0;
  logic          done     = 1'b0;
  logic          sink_req = 1'b0;
  logic [3:0]    sink_exp = 4'h0;
  logic          prev_rst = 1'b1;
  logic [NI-1:0][3:0] hold = '0;

  task automatic cmp(input string name, input int i, input logic [15:0] got,
                     input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cyc, got, want);
    end
  endtask

  always @(negedge CK) begin
    int  idx;
    logic exp_rdy;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (idx < 0 && exp_q[j].inst == i) idx = j;
        if (prev_rst) hold[i] = 4'h0;
        if (ce[i] === 1'b1) begin
          if (idx >= 0 && exp_q[idx].cyc == cyc) begin
            cmp("strobe_d", i, 16'(d[i]), 16'(exp_q[idx].nib));
            cmp("strobe_last", i, 16'(last[i]), 16'(exp_q[idx].lst));
            hold[i] = exp_q[idx].nib;
            exp_q.delete(idx);
          end else begin
            cmp("unexpected_strobe", i, 16'(ce[i]), 16'h0);
          end
        end else begin
          if (idx >= 0 && exp_q[idx].cyc <= cyc) begin
            cmp("missing_strobe", i, 16'(ce[i]), 16'h1);
            exp_q.delete(idx);
          end
          cmp("held_d", i, 16'(d[i]), 16'(hold[i]));
          cmp("last_idle", i, 16'(last[i]), 16'h0);
        end
        exp_rdy = !(busy_from[i] <= cyc && cyc < ready_at[i]);
        cmp("rdy", i, 16'(rdy[i]), 16'(exp_rdy));
        cmp("busy", i, 16'(busy[i]), 16'(!exp_rdy));
        if (sink_req) cmp("sink", i, 16'(sink[i]), 16'(sink_exp));
      end
      sink_req = 1'b0;
    end
    prev_rst = RST;
    if (done) begin
      for (int j = 0; j < exp_q.size(); j++)
        cmp("pending_strobe", exp_q[j].inst, 16'(exp_q[j].cyc), 16'hFFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    for (int i = 0; i < NI; i++) begin
      busy_from[i] = 0;
      ready_at[i]  = 0;
      acc_cnt[i]   = 0;
    end

    // Reset, then idle with LD low.
    drive(1'b0, '0, 1'b1);
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b1);
    idle(10);

    // Single word. The sink ends up holding the top nibble.
    drive(1'b1, 16'hA5C3, 1'b0);
    idle(14);
    sink_exp = 4'hA;
    sink_req = 1'b1;
    idle(1);

    // This word shows the gap spacing on the GAP=2 instance.
    drive(1'b1, 16'h1234, 1'b0);
    idle(14);

    // Back-to-back loads with LD held high.
    base = acc_cnt[0];
    for (int k = 0; k < 40 && acc_cnt[0] - base < 2; k++)
      drive(1'b1, (acc_cnt[0] == base) ? 16'h00FF : 16'hFF00, 1'b0);
    idle(20);

    // Load attempt while a word is in flight must be ignored.
    drive(1'b1, 16'h3C5A, 1'b0);
    idle(1);
    drive(1'b1, 16'hBEEF, 1'b0);
    idle(14);

    // Abort mid-word, then a clean word afterwards.
    drive(1'b1, 16'h9876, 1'b0);
    idle(1);
    drive(1'b0, W, 1'b1);
    idle(3);
    drive(1'b1, 16'h0001, 1'b0);
    idle(15);

    // RST and LD in the same cycle: RST wins.
    drive(1'b1, 16'h7777, 1'b1);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++)
      drive(($urandom % 3) == 0, WW'($urandom), ($urandom % 50) == 0);
    idle(30);

    done = 1'b1;
    repeat (5) @(posedge CK);
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1, "bench did not terminate");
  end

endmodule

// File: doc/nib_ser.md
# nib_ser

Nibble serializer: the sending end of the 4-bit CE-strobed nibble bus. The sink is a 4-bit clock-enabled register whose D input is driven by this block's D and whose enable is driven by its CE. The block accepts a parallel word over a LD/RDY handshake and emits it as NNIB consecutive nibbles, least-significant first. Each nibble is qualified by a single-cycle CE strobe, with an optional fixed idle gap between strobes.

## Interface
Parameters:
- NNIB, default 4: nibbles per word, legal range 2..16; word width is 4*NNIB.
- GAP, default 0: idle cycles inserted between consecutive strobes of one word, legal range 0..15.

Ports (name, direction, width, meaning):
- CK, in, 1: clock. The block uses one clock and all state changes on its rising edge.
- RST, in, 1: reset, synchronous, active-high.
- W, in, 4*NNIB: parallel word to send. Sampled only on acceptance.
- LD, in, 1: load request. The word is accepted on a rising edge where LD=1 and RDY=1.
- RDY, out, 1: block can accept a word.
- D, out, 4: current nibble. Connects to the sink's D.
- CE, out, 1: one-cycle strobe. D is valid while CE=1. Connects to the sink's CE.
- LAST, out, 1: high together with CE on the final nibble of a word.
- BUSY, out, 1: a word is in flight. Equal to ~RDY.

## Operation
- Internal state:
  - Shift register SR, width 4*NNIB.
  - Nibble counter NC, width ceil(log2(NNIB)).
  - Gap counter GC, 4 bits.
  - FSM with states IDLE, SEND, WAIT.
- IDLE:
  - RDY=1 and CE=0.
  - On LD=1: SR<=W, NC<=0, go to SEND.
  - LD=0: stay in IDLE.
- SEND (each cycle in this state emits exactly one nibble):
  - CE=1 and D=SR[3:0].
  - LAST=1 iff NC==NNIB-1.
  - If LAST: go to IDLE.
  - Otherwise: SR<=SR>>4, NC<=NC+1. If GAP==0 stay in SEND; else GC<=GAP-1 and go to WAIT.
- WAIT:
  - CE=0 and D holds the last emitted nibble.
  - GC decrements each cycle. When GC==0, go to SEND.
- D is registered. It changes only at the edge entering SEND and holds its value otherwise, including in IDLE after a word completes.
- LD asserted while RDY=0 is ignored. The word is not queued and W is not sampled.
- W may change freely except on the cycle of acceptance.
- Reset values: RDY=1, BUSY=0, CE=0, LAST=0, D=4'h0, SR=0, NC=0, GC=0, FSM=IDLE.
- RST mid-word aborts the word. Outputs take their reset values at that edge, and no further CE occurs for the aborted word.
- RST and LD in the same cycle: RST wins and the word is not accepted.

## Timing
- Acceptance at edge k produces the first CE (nibble 0 = W[3:0]) in cycle k+1.
- Nibble i strobes in cycle k+1+i*(GAP+1).
- The last nibble strobes in cycle k+1+(NNIB-1)*(GAP+1), with LAST=1 in that cycle.
- RDY rises in the cycle after the LAST strobe. Earliest next acceptance is at the end of that cycle.
- Word period at back-to-back load: (NNIB-1)*(GAP+1)+2 cycles. For the defaults (NNIB=4, GAP=0) this is 5 cycles.
- CE is never high on two consecutive cycles when GAP>0. CE is never high while RDY=1.
- Outputs are glitch-free registered signals. The sink captures D on the same edge where CE=1.

## Test plan
- Reset then idle. Hold RST=1 for 2 cycles, release with LD=0 for 10 cycles. Expect RDY=1, CE=0, LAST=0, D=0 throughout.
- Single word at defaults. W=16'hA5C3 with LD pulsed at edge k. Expect CE=1 in cycles k+1..k+4 with D=3,C,5,A. LAST=1 only in cycle k+4. RDY=0 in k+1..k+4 and RDY=1 in k+5. The sink register holds 4'hA afterwards.
- Gap insertion, GAP=2. W=16'h1234. Expect strobes in cycles k+1, k+4, k+7, k+10 with D=4,3,2,1. D is held between strobes. LAST=1 at k+10 only.
- Back-to-back loads. LD held high, with W=16'h00FF then 16'hFF00. Expect acceptance at k and k+5. D sequence is F,F,0,0,0,0,F,F, with a single CE=0 cycle (k+5) between words.
- Ignored load. Pulse LD with W=16'hBEEF during cycle k+2 of a word in flight. Expect that word's nibbles unchanged, no extra strobes, and RDY=1 at k+5.
- Abort. Assert RST at cycle k+2 of word 16'h9876. Expect CE=0 and D=0 from k+3 onward, and RDY=1. A new W=16'h0001 loaded afterwards strobes 1,0,0,0 normally.
